datapath_mdu: RTL

Parametrised successor to the single-cycle integer datapath. It contains the register file, the single-cycle ALU, the operand and write-back muxes, and load-data extension sized by `funct3`. It adds an iterative RV32M/RV64M multiply/divide unit with a stall handshake toward the control unit. It sits between the control/decode logic and data memory of the single-cycle core.

---
 rtl/datapath_mdu_if.sv | 43 ++++
 rtl/datapath_mdu.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/datapath_mdu_if.sv
// Bus between the control unit and datapath_mdu.
// master: control side (drives register indices, immediates, selects and op codes)
// slave : datapath side (returns compare flags, bus outputs and the stall request)
interface datapath_mdu_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
);
    localparam int unsigned AW = $clog2(NREG);

    logic [AW-1:0]   RD;
    logic [AW-1:0]   RS1;
    logic [AW-1:0]   RS2;
    logic [XLEN-1:0] IMM;
    logic [XLEN-1:0] Data_In;
    logic [XLEN-1:0] PC;
    logic            MD;
    logic            MB;
    logic            MP;
    logic            RW;
    logic            ME;
    logic [3:0]      FS;
    logic [2:0]      funct3;

    logic            V;
    logic            C;
    logic            N;
    logic            Z;
    logic            L;
    logic [XLEN-1:0] RS1_out;
    logic [XLEN-1:0] Data_out;
    logic [XLEN-1:0] Addres_out;
    logic            stall;

    modport master (
        output RD, RS1, RS2, IMM, Data_In, PC, MD, MB, MP, RW, ME, FS, funct3,
        input  V, C, N, Z, L, RS1_out, Data_out, Addres_out, stall
    );

    modport slave (
        input  RD, RS1, RS2, IMM, Data_In, PC, MD, MB, MP, RW, ME, FS, funct3,
        output V, C, N, Z, L, RS1_out, Data_out, Addres_out, stall
    );
endinterface

// File: rtl/datapath_mdu.sv
// Single-cycle integer datapath with an iterative RV32M/RV64M multiply/divide unit.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-low reset
//   bus   - datapath_mdu_if.slave: register indices, IMM/PC/Data_In, selects
//           (MD/MB/MP/RW/ME), FS, funct3 in; V/C/N/Z/L flags, RS1_out (A),
//           Data_out (B), Addres_out (ALU result G) and combinational stall out.
module datapath_mdu #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input logic           clk,
    input logic           reset,
    datapath_mdu_if.slave bus
);
    localparam int unsigned SW = $clog2(XLEN);
    localparam int unsigned DW = 2 * XLEN;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [2:0]      op_q, op_d;
    logic            neg_a_q, neg_a_d;
    logic            neg_r_q, neg_r_d;
    logic            bz_q, bz_d;
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    logic [XLEN-1:0] ra, rb, muxp, muxb, alu_g, ld_ext, mdu_res, wr_data;
    logic [XLEN-1:0] a_mag, b_mag, quo, rem;
    logic [DW-1:0]   prod, mul_step, div_step;
    logic [XLEN:0]   diff, mul_sum, div_sh, div_diff;
    logic [SW-1:0]   shamt;
    logic            s_a_op, s_b_op, sa, sb, wr_en;

    // Register file read ports; x0 is hard-wired to zero
    assign ra = (bus.RS1 == '0) ? '0 : regs_q[bus.RS1];
    assign rb = (bus.RS2 == '0) ? '0 : regs_q[bus.RS2];

    // ALU operand muxes and function select
    assign muxp  = bus.MP ? bus.PC  : ra;
    assign muxb  = bus.MB ? bus.IMM : rb;
    assign shamt = muxb[SW-1:0];

    always_comb begin
        alu_g = '0;
        case (bus.FS)
            4'd0:    alu_g = muxp + muxb;
            4'd1:    alu_g = muxp - muxb;
            4'd2:    alu_g = muxp & muxb;
            4'd3:    alu_g = muxp | muxb;
            4'd4:    alu_g = muxp ^ muxb;
            4'd5:    alu_g = muxp << shamt;
            4'd6:    alu_g = muxp >> shamt;
            4'd7:    alu_g = XLEN'($signed(muxp) >>> shamt);
            4'd8:    alu_g = XLEN'($signed(muxp) < $signed(muxb));
            4'd9:    alu_g = XLEN'(muxp < muxb);
            4'd10:   alu_g = muxb;
            default: alu_g = '0;
        endcase
    end

    // Flags always come from MuxP - MuxB; the extra MSB is the borrow
    assign diff  = {1'b0, muxp} - {1'b0, muxb};
    assign bus.Z = (diff[XLEN-1:0] == '0);
    assign bus.N = diff[XLEN-1];
    assign bus.C = ~diff[XLEN];
    assign bus.V = (muxp[XLEN-1] ^ muxb[XLEN-1]) & (diff[XLEN-1] ^ muxp[XLEN-1]);
    assign bus.L = bus.N ^ bus.V;

    // Load-data extension sized by funct3
    always_comb begin
        ld_ext = bus.Data_In;
        case (bus.funct3)
            3'b000:  ld_ext = XLEN'($signed(bus.Data_In[7:0]));
            3'b001:  ld_ext = XLEN'($signed(bus.Data_In[15:0]));
            3'b010:  ld_ext = XLEN'($signed(bus.Data_In[31:0]));
            3'b100:  ld_ext = XLEN'(bus.Data_In[7:0]);
            3'b101:  ld_ext = XLEN'(bus.Data_In[15:0]);
            3'b110:  ld_ext = XLEN'(bus.Data_In[31:0]);
            default: ld_ext = bus.Data_In;
        endcase
    end

    // Operand signedness at issue: MULHU/DIVU/REMU unsigned, MULHSU signed A only
    assign s_a_op = (bus.funct3 != 3'b011) && (bus.funct3 != 3'b101) && (bus.funct3 != 3'b111);
    assign s_b_op = s_a_op && (bus.funct3 != 3'b010);
    assign sa     = s_a_op && ra[XLEN-1];
    assign sb     = s_b_op && rb[XLEN-1];
    assign a_mag  = sa ? -ra : ra;
    assign b_mag  = sb ? -rb : rb;

    // Shift-add: multiplier sits in the low half and shifts out as the product shifts in
    assign mul_sum  = {1'b0, acc_q[DW-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring divide: partial remainder in the high half, quotient bits fill the low half
    assign div_sh   = acc_q[DW-1:XLEN-1];
    assign div_diff = div_sh - {1'b0, opb_q};
    assign div_step = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    // Sign fix-up and divide-by-zero override of the finished MDU result
    always_comb begin
        prod    = neg_r_q ? -acc_q : acc_q;
        quo     = neg_r_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem     = neg_a_q ? -acc_q[DW-1:XLEN] : acc_q[DW-1:XLEN];
        mdu_res = prod[XLEN-1:0];
        case (op_q)
            3'b001, 3'b010, 3'b011: mdu_res = prod[DW-1:XLEN];
            3'b100, 3'b101:         mdu_res = bz_q ? '1 : quo;
            3'b110, 3'b111:         mdu_res = bz_q ? dvd_q : rem;
            default:                mdu_res = prod[XLEN-1:0];
        endcase
    end

    // Write-back: ALU/load only in IDLE without ME, MDU result only in DONE
    assign wr_en   = bus.RW && (bus.RD != '0) &&
                     (((state_q == S_IDLE) && !bus.ME) || (state_q == S_DONE));
    assign wr_data = (state_q == S_DONE) ? mdu_res : (bus.MD ? ld_ext : alu_g);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[bus.RD] = wr_data;
    end

    // MDU sequencing: IDLE latches operands, BUSY iterates XLEN times, DONE writes back
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        dvd_d   = dvd_q;
        op_d    = op_q;
        neg_a_d = neg_a_q;
        neg_r_d = neg_r_q;
        bz_d    = bz_q;
        case (state_q)
            S_IDLE: begin
                if (bus.ME) begin
                    state_d = S_BUSY;
                    cnt_d   = SW'(XLEN - 1);
                    op_d    = bus.funct3;
                    acc_d   = {XLEN'(0), a_mag};
                    opb_d   = b_mag;
                    dvd_d   = ra;
                    bz_d    = (rb == '0);
                    neg_a_d = sa;
                    neg_r_d = sa ^ sb;
                end
            end
            S_BUSY: begin
                acc_d = op_q[2] ? div_step : mul_step;
                cnt_d = cnt_q - SW'(1);
                if (cnt_q == '0) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            dvd_q   <= '0;
            op_q    <= '0;
            neg_a_q <= 1'b0;
            neg_r_q <= 1'b0;
            bz_q    <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            dvd_q   <= dvd_d;
            op_q    <= op_d;
            neg_a_q <= neg_a_d;
            neg_r_q <= neg_r_d;
            bz_q    <= bz_d;
            regs_q  <= regs_d;
        end
    end

    assign bus.RS1_out    = ra;
    assign bus.Data_out   = rb;
    assign bus.Addres_out = alu_g;
    assign bus.stall      = (state_q == S_BUSY) || ((state_q == S_IDLE) && bus.ME);
endmodule
